// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU result path
// and the load result path. Loads win by default. An ALU request that has been
// refused MAX_WAIT cycles in a row is forced through. The winning request is
// registered onto the wr_* port one cycle after acceptance.
//
// Optional feature macro: WB_FWD_EN adds rs_addr/rt_addr/fwd_hit/fwd_data,
// which forward the in-flight registered write to operand reads.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic [1:0]  mem_size,
  input  logic        wr_stall,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic        wr_src
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [1:0]  fwd_hit,
  output logic [31:0] fwd_data
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          alu_forced;
  logic          alu_accept;
  logic          mem_accept;
  logic [3:0]    mem_be;

  assign alu_forced = (wait_cnt == WAIT_SAT);
  assign alu_accept = alu_valid && alu_ready;
  assign mem_accept = mem_valid && mem_ready;

  // Arbitration: nothing moves during a stall; a lone requester always wins;
  // on contention the load wins unless the ALU has waited long enough.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!wr_stall) begin
      if (alu_valid && mem_valid) begin
        if (alu_forced) alu_ready = 1'b1;
        else            mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end
    end
  end

  // Load byte enables from access size; size 11 is treated as a full word.
  always_comb begin
    case (mem_size)
      2'b00:   mem_be = 4'b0001;
      2'b01:   mem_be = 4'b0011;
      default: mem_be = 4'b1111;
    endcase
  end

  // Starvation counter: counts consecutive refused ALU cycles, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!wr_stall) begin
      if (alu_accept)
        wait_cnt <= '0;
      else if (alu_valid && !alu_forced)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered write stage; holds completely while the register file stalls.
  // Writes to register 0 are consumed but never strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_be   <= '0;
      wr_src  <= 1'b0;
    end else if (!wr_stall) begin
      if (alu_accept) begin
        wr_en   <= (alu_addr != 5'd0);
        wr_addr <= alu_addr;
        wr_data <= alu_data;
        wr_be   <= 4'b1111;
        wr_src  <= 1'b0;
      end else if (mem_accept) begin
        wr_en   <= (mem_addr != 5'd0);
        wr_addr <= mem_addr;
        wr_data <= mem_data;
        wr_be   <= mem_be;
        wr_src  <= 1'b1;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  logic wr_live;
  assign wr_live = wr_en && !wr_stall && (wr_addr != 5'd0);

  // Forward the in-flight write; bytes outside wr_be read as zero.
  always_comb begin
    fwd_hit[0] = wr_live && (wr_addr == rs_addr);
    fwd_hit[1] = wr_live && (wr_addr == rt_addr);
    fwd_data   = wr_data & {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two requesters: the ALU result path and the load (memory) result path. It accepts requests over valid/ready handshakes, picks one winner per cycle with load-priority plus an ALU starvation guard, and drives a registered write command (address, data, byte enables) into the register file one cycle later. It sits between the execute/memory stages and the register file.

## Interface
- MAX_WAIT, 3: consecutive cycles the ALU may be refused before it is forced to win (1..15).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU write request present.
- alu_ready  output  1  ALU request accepted this cycle (combinational).
- alu_addr  input  5  ALU destination register.
- alu_data  input  32  ALU write data.
- mem_valid  input  1  load write request present.
- mem_ready  output  1  load request accepted this cycle (combinational).
- mem_addr  input  5  load destination register.
- mem_data  input  32  load data, right-aligned.
- mem_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- wr_stall  input  1  register file cannot take a write this cycle.
- wr_en  output  1  registered write strobe.
- wr_addr  output  5  registered write address.
- wr_data  output  32  registered write data.
- wr_be  output  4  registered byte enables, bit 0 = bits [7:0].
- wr_src  output  1  0 = ALU, 1 = load.

## Operation
- Transfer occurs on valid && ready. Requesters hold valid, addr, data and size stable until accepted.
- While wr_stall = 1, both readies are 0.
- Otherwise, when only one requester is valid, that requester is ready.
- When both requesters are valid, the load wins by default.
  - The ALU wins instead when wait_cnt == MAX_WAIT.
- wait_cnt (width $clog2(MAX_WAIT+1)) behaviour:
  - Increments, saturating at MAX_WAIT, in each cycle with alu_valid && !alu_ready && !wr_stall.
  - Clears to 0 on ALU acceptance.
  - Holds during wr_stall.
- Byte enables:
  - ALU: 4'b1111.
  - Load: 00 → 4'b0001, 01 → 4'b0011, 10/11 → 4'b1111.
- Data passes unmodified. Merging with old register contents is the register file's job, using wr_be.
- Accepted request with destination register 0: consumed (ready = 1), but the next-cycle wr_en = 0. wr_addr/wr_data/wr_be/wr_src still load.
- At most one acceptance per cycle. alu_ready and mem_ready are never both 1.

## Timing
- Reset (rst_n low, asynchronous): wr_en = 0, wr_addr = 0, wr_data = 0, wr_be = 0, wr_src = 0, wait_cnt = 0.
- Readies are combinational from valids, wr_stall and wait_cnt. During reset they follow the same rule; no transfer is recorded until rst_n is high at a clock edge.
- Latency: a request accepted at edge N appears on wr_* after edge N (valid during cycle N+1). Throughput is one write per cycle.
- No transfer in a cycle: wr_en = 0 next cycle; other wr_* hold.
- wr_stall = 1: all wr_* outputs hold their values, including wr_en. The register file must ignore wr_en while it asserts wr_stall.
- Reset asserted mid-operation: a pending wr_en is dropped and the starvation count is lost.

## Configuration
- WB_FWD_EN defined: adds four ports that forward the in-flight write to operand reads.
  - rs_addr input 5, rt_addr input 5.
  - fwd_hit output 2: bit0 = rs match, bit1 = rt match.
  - fwd_data output 32.
  - A hit is wr_en && !wr_stall && wr_addr == rs_addr (likewise for rt). A hit is never raised for address 0.
  - fwd_data = wr_data, with the bytes not covered by wr_be forced to 0.
  - All four signals are combinational from the registered write stage.
- WB_FWD_EN undefined: these ports are absent and no compare logic is built.

## Test plan
- Reset, then ALU only: alu_addr = 5, alu_data = 0x12345678 → alu_ready = 1. Next cycle wr_en = 1, wr_addr = 5, wr_data = 0x12345678, wr_be = 4'hF, wr_src = 0.
- Both valid for 8 cycles with MAX_WAIT = 3 (the load is re-presented with a new request after each acceptance) → acceptances in order: load, load, load, ALU, load, load, load, ALU.
- Load with mem_size = 01, mem_data = 0x0000BEEF, addr 9 → next cycle wr_be = 4'h3, wr_src = 1, wr_data = 0x0000BEEF.
- ALU request to register 0 → alu_ready = 1; next cycle wr_en = 0 and wait_cnt = 0.
- wr_stall high for 3 cycles with both valid → both readies 0, wr_* held, wait_cnt unchanged. On release, the normal priority order resumes.
- WB_FWD_EN: write in flight to register 7 with wr_be = 4'h1 and wr_data = 0xAABBCCDD, rs_addr = 7 → fwd_hit = 2'b01, fwd_data = 0x000000DD. Asserting rst_n low mid-sequence → wr_en = 0 immediately.
